serializer: RTL and testbench

- Transmit-side counterpart of the team's parallelizer.
- Accepts one wide bundle of `regs` N-bit words over a val/rdy receive interface, buffers it, and emits the words one per handshake over an N-bit val/rdy send interface.
- Sits between wide parallel logic and the narrow SERDES link; word 0 is sent first.

---
 rtl/serializer_pkg.sv | 15 +
 rtl/serializer_ctrl.sv | 94 +++++++++
 rtl/serializer.sv | 67 ++++++
 tb/tb_serializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and defaults for the bundle-to-word serializer
//
// Purpose: FSM state encoding and default word width used by serializer and serializer_ctrl.
// Ports:   none (package).
// Build:   optional back-to-back streaming is enabled by defining SERIALIZER_BACK_TO_BACK_EN.
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEFAULT_N = 32;

endpackage

// File: rtl/serializer_ctrl.sv
// rtl/serializer_ctrl.sv - FSM and word counter for the bundle-to-word serializer
//
// Purpose: sequences one bundle acceptance followed by regs word handshakes.
// Ports:
//   clk        input   clock, rising edge
//   reset      input   synchronous active-high reset
//   recv_val   input   bundle valid from upstream
//   send_rdy   input   downstream accepts a word
//   recv_rdy   output  block can accept a bundle
//   send_val   output  a valid word is presented
//   load_en    output  capture recv_msg into the buffer this cycle
//   count      output  index of the word currently presented
// Build: SERIALIZER_BACK_TO_BACK_EN lets a new bundle load on the last-word handshake;
//        recv_rdy then depends combinationally on send_rdy.
module serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int dec_in = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recv_val,
  input  logic              send_rdy,
  output logic              recv_rdy,
  output logic              send_val,
  output logic              load_en,
  output logic [dec_in-1:0] count
);

  localparam int REGS = 1 << dec_in;
  localparam logic [dec_in-1:0] LAST = dec_in'(REGS - 1);

  state_e            state_q, state_d;
  logic [dec_in-1:0] count_q, count_d;
  logic              last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Handshake outputs are forced low while reset is high so a bundle can
  // never be accepted or a word sent during reset, even mid-bundle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    load_en  = 1'b0;
    last     = (count_q == LAST);
    if (!reset) begin
      case (state_q)
        IDLE: begin
          recv_rdy = 1'b1;
          if (recv_val) begin
            load_en = 1'b1;
            count_d = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          send_val = 1'b1;
`ifdef SERIALIZER_BACK_TO_BACK_EN
          // Ready for the next bundle exactly when the last word leaves.
          if (last) recv_rdy = send_rdy;
`endif
          if (send_rdy) begin
            if (!last) begin
              count_d = count_q + dec_in'(1);
            end else begin
              count_d = '0;
              state_d = IDLE;
`ifdef SERIALIZER_BACK_TO_BACK_EN
              if (recv_val) begin
                load_en = 1'b1;
                state_d = SEND;
              end
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serializer.sv
// rtl/serializer.sv - accepts a regs x N bundle and emits it one N-bit word per handshake
//
// Purpose: transmit-side serializer between wide parallel logic and a narrow link;
//          word 0 is sent first, one cycle after bundle acceptance.
// Ports:
//   clk         input                clock, rising edge
//   reset       input                synchronous active-high reset
//   recv_val    input                bundle valid
//   recv_rdy    output               block can accept a bundle
//   recv_msg    input  [regs*N-1:0]  bundle; word k = recv_msg[k*N +: N]
//   send_val    output               send_msg holds a valid word
//   send_rdy    input                downstream accepts a word
//   send_msg    output [N-1:0]       current word
//   dec_select  output [dec_in-1:0]  index of the word on send_msg
// Build: define SERIALIZER_BACK_TO_BACK_EN for zero-idle streaming of consecutive bundles.
module serializer
  import serializer_pkg::*;
#(
  parameter int dec_in = 1,
  parameter int regs   = 1 << dec_in,
  parameter int N      = DEFAULT_N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recv_val,
  output logic                recv_rdy,
  input  logic [regs*N-1:0]   recv_msg,
  output logic                send_val,
  input  logic                send_rdy,
  output logic [N-1:0]        send_msg,
  output logic [dec_in-1:0]   dec_select
);

  logic              load_en;
  logic [dec_in-1:0] count;
  logic [N-1:0]      word_q [regs];

  serializer_ctrl #(
    .dec_in (dec_in)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .send_rdy (send_rdy),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .load_en  (load_en),
    .count    (count)
  );

  // One enabled register per word; recv_msg is only sampled on load_en.
  for (genvar k = 0; k < regs; k++) begin : g_word
    always_ff @(posedge clk) begin
      if (reset) begin
        word_q[k] <= '0;
      end else if (load_en) begin
        word_q[k] <= recv_msg[k*N +: N];
      end
    end
  end

  // Outputs come only from registered state and the buffer; zeroed when no
  // word is presented so stale buffer contents never leak out.
  assign send_msg   = send_val ? word_q[count] : '0;
  assign dec_select = send_val ? count : '0;

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for serializer
module tb_serializer;

`ifdef SERIALIZER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val, recv_rdy, send_val, send_rdy;
  logic [63:0] recv_msg;
  logic [31:0] send_msg;
  logic [0:0]  dec_select;

  logic         recv_val2, recv_rdy2, send_val2, send_rdy2;
  logic [127:0] recv_msg2;
  logic [31:0]  send_msg2;
  logic [1:0]   dec_select2;

  int total = 0;
  int bad   = 0;

  logic [34:0] exp1;
  logic [35:0] exp2;

  always #5 clk = ~clk;

  serializer #(.dec_in(1), .N(32)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .recv_msg(recv_msg), .send_val(send_val), .send_rdy(send_rdy),
    .send_msg(send_msg), .dec_select(dec_select)
  );

  serializer #(.dec_in(2), .N(32)) dut2 (
    .clk(clk), .reset(reset), .recv_val(recv_val2), .recv_rdy(recv_rdy2),
    .recv_msg(recv_msg2), .send_val(send_val2), .send_rdy(send_rdy2),
    .send_msg(send_msg2), .dec_select(dec_select2)
  );

  // Inputs change on the falling edge; outputs are checked #1 later.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; recv_val = 1'b1; recv_msg = {32'h5555_0002, 32'h5555_0001}; send_rdy = 1'b1;
    recv_val2 = 1'b0; recv_msg2 = '0; send_rdy2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step; #1;
      total++;
      if ({recv_rdy, send_val, send_msg} !== {1'b0, 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL reset_hold[%0d]: rdy/val/msg got %h expected %h", i,
                 {recv_rdy, send_val, send_msg}, {1'b0, 1'b0, 32'h0});
      end
    end
    step; reset = 1'b0; recv_val = 1'b0; #1;
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_release: got %h expected %h",
               {send_val, recv_rdy, send_msg, dec_select}, {1'b0, 1'b1, 32'h0, 1'b0});
    end
  endtask

  task automatic test_single;
    step; recv_val = 1'b1; recv_msg = {32'hBBBB_0002, 32'hAAAA_0001}; send_rdy = 1'b1; #1;
    total++;
    if (recv_rdy !== 1'b1) begin
      bad++; $display("FAIL single_accept: recv_rdy got %b expected 1", recv_rdy);
    end
    step; recv_val = 1'b0; #1;
    exp1 = {1'b1, 1'b0, 32'hAAAA_0001, 1'b0};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL single_word0: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step; #1;
    exp1 = {1'b1, B2B, 32'hBBBB_0002, 1'b1};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL single_word1: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step; #1;
    exp1 = {1'b0, 1'b1, 32'h0, 1'b0};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL single_idle: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
  endtask

  task automatic test_backpressure;
    recv_val = 1'b1; recv_msg = {32'hBBBB_0002, 32'hAAAA_0001}; send_rdy = 1'b0;
    step; recv_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) step;
      #1;
      exp1 = {1'b1, 1'b0, 32'hAAAA_0001, 1'b0};
      total++;
      if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
        bad++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, {send_val, recv_rdy, send_msg, dec_select}, exp1);
      end
    end
    step; send_rdy = 1'b1; #1;
    exp1 = {1'b1, 1'b0, 32'hAAAA_0001, 1'b0};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL bp_release: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step; #1;
    exp1 = {1'b1, B2B, 32'hBBBB_0002, 1'b1};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL bp_word1: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step; #1;
    exp1 = {1'b0, 1'b1, 32'h0, 1'b0};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL bp_idle: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
  endtask

  task automatic test_busy_ignore;
    recv_val = 1'b1; recv_msg = {32'hBBBB_0002, 32'hAAAA_0001}; send_rdy = 1'b0;
    step; recv_msg = {32'h0000_2222, 32'h0000_1111};
    for (int i = 0; i < 2; i++) begin
      if (i != 0) step;
      #1;
      exp1 = {1'b1, 1'b0, 32'hAAAA_0001, 1'b0};
      total++;
      if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
        bad++; $display("FAIL busy_word0[%0d]: got %h expected %h", i, {send_val, recv_rdy, send_msg, dec_select}, exp1);
      end
    end
    step; recv_val = 1'b0; send_rdy = 1'b1;
    step; #1;
    exp1 = {1'b1, B2B, 32'hBBBB_0002, 1'b1};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL busy_word1: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step; #1;
    exp1 = {1'b0, 1'b1, 32'h0, 1'b0};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL busy_idle: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
  endtask

  task automatic test_reset_mid;
    recv_val = 1'b1; recv_msg = {32'hBBBB_0002, 32'hAAAA_0001}; send_rdy = 1'b1;
    step; recv_val = 1'b0; #1;
    exp1 = {1'b1, 1'b0, 32'hAAAA_0001, 1'b0};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL mid_word0: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step; reset = 1'b1; #1;
    total++;
    if ({send_val, recv_rdy, send_msg} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL mid_in_reset: got %h expected %h", {send_val, recv_rdy, send_msg}, {1'b0, 1'b0, 32'h0});
    end
    for (int i = 0; i < 2; i++) begin
      step; reset = 1'b0; #1;
      exp1 = {1'b0, 1'b1, 32'h0, 1'b0};
      total++;
      if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
        bad++; $display("FAIL mid_after[%0d]: got %h expected %h", i, {send_val, recv_rdy, send_msg, dec_select}, exp1);
      end
    end
    recv_val = 1'b1; recv_msg = {32'h5678_0004, 32'h1234_0003};
    step; recv_val = 1'b0; #1;
    exp1 = {1'b1, 1'b0, 32'h1234_0003, 1'b0};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL mid_new_word0: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step; #1;
    exp1 = {1'b1, B2B, 32'h5678_0004, 1'b1};
    total++;
    if ({send_val, recv_rdy, send_msg, dec_select} !== exp1) begin
      bad++; $display("FAIL mid_new_word1: got %h expected %h", {send_val, recv_rdy, send_msg, dec_select}, exp1);
    end
    step;
  endtask

  task automatic test_back_to_back;
    recv_val2 = 1'b1; send_rdy2 = 1'b1;
    recv_msg2 = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int c = 1; c <= 10; c++) begin
      step;
      if (c == 1) recv_msg2 = {32'd8, 32'd7, 32'd6, 32'd5};
      if (c == 6) recv_val2 = 1'b0;
      #1;
      if (B2B) begin
        if (c <= 8) exp2 = {1'b1, (c == 4 || c == 8), 32'(c), 2'((c - 1) % 4)};
        else        exp2 = {1'b0, 1'b1, 32'h0, 2'd0};
      end else begin
        if (c <= 4)      exp2 = {1'b1, 1'b0, 32'(c), 2'(c - 1)};
        else if (c == 5) exp2 = {1'b0, 1'b1, 32'h0, 2'd0};
        else if (c <= 9) exp2 = {1'b1, 1'b0, 32'(c - 1), 2'(c - 6)};
        else             exp2 = {1'b0, 1'b1, 32'h0, 2'd0};
      end
      total++;
      if ({send_val2, recv_rdy2, send_msg2, dec_select2} !== exp2) begin
        bad++; $display("FAIL b2b_cycle[%0d]: got %h expected %h", c, {send_val2, recv_rdy2, send_msg2, dec_select2}, exp2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
